// File: rtl/rx_drain_ctrl_if.sv
// Rx FIFO read port and host valid/ready port of rx_drain_ctrl, bundled as one interface.
// master = drain controller side, slave = FIFO/host side.
interface rx_drain_ctrl_if;
    logic [7:0] FifoData_i;
    logic       n_FifoRd_o;
    logic       p_FifoEmpty_i;
    logic [7:0] Data_o;
    logic       p_Valid_o;
    logic       p_Ready_i;

    modport master (
        input  FifoData_i, p_FifoEmpty_i, p_Ready_i,
        output n_FifoRd_o, Data_o, p_Valid_o
    );

    modport slave (
        output FifoData_i, p_FifoEmpty_i, p_Ready_i,
        input  n_FifoRd_o, Data_o, p_Valid_o
    );
endinterface

// File: rtl/rx_drain_ctrl.sv
// Rx FIFO drain sequencer: pops one byte at a time to a valid/ready host port, counts errors/bytes.
// Optional idle-timeout pulse is built only when RX_TIMEOUT_EN is defined.
module rx_drain_ctrl #(
    parameter int CNT_W       = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic             clk,
    input  logic             rst,
    rx_drain_ctrl_if.master  bus,
    input  logic             p_Enable_i,
    input  logic             p_BaudrateError_i,
    input  logic             p_ParityError_i,
    input  logic             p_CntClr_i,
    output logic [CNT_W-1:0] BaudErrCnt_o,
    output logic [CNT_W-1:0] ParErrCnt_o,
    output logic [CNT_W-1:0] ByteCnt_o,
    output logic             p_Timeout_o
);

    typedef enum logic [1:0] {IDLE, CAPT, HOLD} state_t;

    state_t state;
    logic   pop;
    logic   accept;
    logic   baud_p1, baud_p2, par_p1, par_p2;
    logic   baud_rise, par_rise;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The strobe must fall in the same IDLE cycle so the FIFO data lands while in CAPT.
    assign pop            = !rst && (state == IDLE) && p_Enable_i && !bus.p_FifoEmpty_i;
    assign bus.n_FifoRd_o = !pop;
    assign accept         = (state == HOLD) && bus.p_Valid_o && bus.p_Ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            bus.Data_o    <= 8'h00;
            bus.p_Valid_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (pop) state <= CAPT;
                CAPT: begin
                    bus.Data_o    <= bus.FifoData_i;
                    bus.p_Valid_o <= 1'b1;
                    state         <= HOLD;
                end
                HOLD: if (accept) begin
                    bus.p_Valid_o <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Error inputs: one register stage, then edge detect against the previous sample
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_p1 <= 1'b0;
            baud_p2 <= 1'b0;
            par_p1  <= 1'b0;
            par_p2  <= 1'b0;
        end else begin
            baud_p1 <= p_BaudrateError_i;
            baud_p2 <= baud_p1;
            par_p1  <= p_ParityError_i;
            par_p2  <= par_p1;
        end
    end

    assign baud_rise = baud_p1 && !baud_p2;
    assign par_rise  = par_p1 && !par_p2;

    always_ff @(posedge clk) begin
        if (rst || p_CntClr_i) begin
            BaudErrCnt_o <= '0;
            ParErrCnt_o  <= '0;
            ByteCnt_o    <= '0;
        end else begin
            if (baud_rise) BaudErrCnt_o <= sat_inc(BaudErrCnt_o);
            if (par_rise)  ParErrCnt_o  <= sat_inc(ParErrCnt_o);
            if (accept)    ByteCnt_o    <= sat_inc(ByteCnt_o);
        end
    end

`ifdef RX_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

    logic [IDLE_W-1:0] idle_cnt;

    // A non-empty FIFO covers every pop, so it alone re-arms the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idle_cnt    <= '0;
            p_Timeout_o <= 1'b0;
        end else begin
            p_Timeout_o <= 1'b0;
            if (!bus.p_FifoEmpty_i) begin
                idle_cnt <= '0;
            end else if ((state == IDLE) && p_Enable_i && (idle_cnt != IDLE_W'(TIMEOUT_CYC))) begin
                idle_cnt <= idle_cnt + IDLE_W'(1);
                if (idle_cnt == IDLE_W'(TIMEOUT_CYC - 1)) p_Timeout_o <= 1'b1;
            end
        end
    end
`else
    assign p_Timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Randomized self-checking bench for rx_drain_ctrl with a queue FIFO model and in-order scoreboard.
module tb_rx_drain_ctrl;
    localparam int CNT_W = 3;
    localparam int TOC   = 16;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enable = 1'b0, berr = 1'b0, perr = 1'b0, clr = 1'b0;
    logic [CNT_W-1:0] bcnt, pcnt, bytecnt;
    logic timeout;

    rx_drain_ctrl_if bus ();

    rx_drain_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TOC)) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .p_Enable_i(enable), .p_BaudrateError_i(berr), .p_ParityError_i(perr),
        .p_CntClr_i(clr), .BaudErrCnt_o(bcnt), .ParErrCnt_o(pcnt),
        .ByteCnt_o(bytecnt), .p_Timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    int pops = 0, accepts = 0, underflow = 0, overrun = 0, unstable = 0;
    int to_cnt = 0, last_to_cyc = 0, last_acc_cyc = 0;
    int exp_bytecnt = 0;
    logic hold_chk = 1'b0;
    logic [7:0] held = 8'h00;
    logic [7:0] fifo_q[$];
    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];

    initial begin
        bus.FifoData_i    = 8'h00;
        bus.p_FifoEmpty_i = 1'b1;
        bus.p_Ready_i     = 1'b0;
    end

    always @(posedge clk) cyc++;

    // FIFO model: data appears the cycle after the strobe
    always @(posedge clk) begin
        if (!rst && !bus.n_FifoRd_o) begin
            if (fifo_q.size() == 0) underflow++;
            else bus.FifoData_i <= fifo_q.pop_front();
            bus.p_FifoEmpty_i <= (fifo_q.size() == 0);
        end
    end

    // Host-side monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst) begin
            if (!bus.n_FifoRd_o) pops++;
            if (hold_chk && (!bus.p_Valid_o || bus.Data_o !== held)) unstable++;
            hold_chk = bus.p_Valid_o && !bus.p_Ready_i;
            held     = bus.Data_o;
            if (bus.p_Valid_o && bus.p_Ready_i) begin
                got_q.push_back(bus.Data_o);
                accepts++;
                exp_bytecnt  = (exp_bytecnt >= MAXC) ? MAXC : exp_bytecnt + 1;
                last_acc_cyc = cyc;
            end
            if (pops - accepts > 1) overrun++;
            if (timeout) begin
                to_cnt++;
                last_to_cyc = cyc;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        fifo_q.push_back(b);
        exp_q.push_back(b);
        bus.p_FifoEmpty_i = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        exp_bytecnt = 0;
        @(negedge clk);
        tests++; if (bus.n_FifoRd_o !== 1'b1) begin fails++; $display("FAIL reset_rd: got %b required 1", bus.n_FifoRd_o); end
        tests++; if (bus.p_Valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b required 0", bus.p_Valid_o); end
        tests++; if (bus.Data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h required 00", bus.Data_o); end
        tests++; if (bcnt !== '0) begin fails++; $display("FAIL reset_baudcnt: got %0d required 0", bcnt); end
        tests++; if (pcnt !== '0) begin fails++; $display("FAIL reset_parcnt: got %0d required 0", pcnt); end
        tests++; if (bytecnt !== '0) begin fails++; $display("FAIL reset_bytecnt: got %0d required 0", bytecnt); end
        tests++; if (timeout !== 1'b0) begin fails++; $display("FAIL reset_timeout: got %b required 0", timeout); end
    endtask

    task automatic test_single;
        bit found = 0;
        logic [7:0] g;
        enable = 1'b1;
        bus.p_Ready_i = 1'b1;
        tick(1);
        push(8'hA5);
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge clk);
            found = !bus.n_FifoRd_o;
        end
        tests++; if (!found) begin fails++; $display("FAIL single_pop: got no strobe, required strobe"); end
        @(negedge clk);
        tests++; if (bus.n_FifoRd_o !== 1'b1) begin fails++; $display("FAIL single_strobe_len: got %b required 1", bus.n_FifoRd_o); end
        @(negedge clk);
        tests++; if (bus.p_Valid_o !== 1'b1 || bus.Data_o !== 8'hA5) begin
            fails++; $display("FAIL single_valid: got valid=%b data=%h required valid=1 data=a5", bus.p_Valid_o, bus.Data_o); end
        @(negedge clk);
        tests++; if (int'(bytecnt) !== 1 || bus.p_Valid_o !== 1'b0) begin
            fails++; $display("FAIL single_bytecnt: got cnt=%0d valid=%b required cnt=1 valid=0", bytecnt, bus.p_Valid_o); end
        g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
        void'(exp_q.pop_front());
        tests++; if (g !== 8'hA5) begin fails++; $display("FAIL single_scoreboard: got %h required a5", g); end
    endtask

    task automatic test_backpressure;
        int p0, a0, bad;
        logic [7:0] first;
        tick(1);
        p0 = pops; a0 = accepts;
        bus.p_Ready_i = 1'b0;
        first = 8'($urandom);
        push(first);
        push(8'($urandom));
        push(8'($urandom));
        tick(10);
        @(negedge clk);
        tests++; if (pops - p0 !== 1) begin fails++; $display("FAIL bp_one_pop: got %0d pops required 1", pops - p0); end
        tests++; if (bus.p_Valid_o !== 1'b1 || bus.Data_o !== first) begin
            fails++; $display("FAIL bp_hold: got valid=%b data=%h required valid=1 data=%h", bus.p_Valid_o, bus.Data_o, first); end
        tick(1);
        bus.p_Ready_i = 1'b1;
        for (int i = 0; i < 50 && (accepts - a0) < 3; i++) @(negedge clk);
        tests++; if (accepts - a0 !== 3) begin fails++; $display("FAIL bp_delivered: got %0d required 3", accepts - a0); end
        tests++; if (pops - p0 !== 3) begin fails++; $display("FAIL bp_pops: got %0d required 3", pops - p0); end
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        tests++; if (bad !== 0) begin fails++; $display("FAIL bp_order: got %0d wrong bytes required 0", bad); end
        @(negedge clk);
        tests++; if (int'(bytecnt) !== exp_bytecnt) begin fails++; $display("FAIL bp_bytecnt: got %0d required %0d", bytecnt, exp_bytecnt); end
        tests++; if (unstable !== 0) begin fails++; $display("FAIL bp_stable: got %0d changes required 0", unstable); end
    endtask

    task automatic test_empty;
        int p0, vc;
        tick(2);
        p0 = pops; vc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (bus.p_Valid_o) vc++;
        end
        tests++; if (pops - p0 !== 0) begin fails++; $display("FAIL empty_pops: got %0d required 0", pops - p0); end
        tests++; if (vc !== 0) begin fails++; $display("FAIL empty_valid: got %0d valid cycles required 0", vc); end
    endtask

    task automatic test_enable_drop;
        int p0, a0, bad;
        tick(1);
        p0 = pops; a0 = accepts;
        bus.p_Ready_i = 1'b0;
        push(8'h3C);
        push(8'hC3);
        for (int i = 0; i < 20 && !bus.p_Valid_o; i++) @(negedge clk);
        tick(1);
        enable = 1'b0;
        tick(1);
        bus.p_Ready_i = 1'b1;
        tick(10);
        tests++; if (accepts - a0 !== 1 || pops - p0 !== 1) begin
            fails++; $display("FAIL endrop_stop: got accepts=%0d pops=%0d required 1 and 1", accepts - a0, pops - p0); end
        enable = 1'b1;
        for (int i = 0; i < 30 && (accepts - a0) < 2; i++) @(negedge clk);
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        tests++; if (accepts - a0 !== 2 || bad !== 0) begin
            fails++; $display("FAIL endrop_resume: got accepts=%0d bad=%0d required 2 and 0", accepts - a0, bad); end
    endtask

    task automatic test_errors;
        tick(1);
        clr = 1'b1; tick(1); clr = 1'b0;
        exp_bytecnt = 0;
        tick(1);
        for (int i = 0; i < 3; i++) begin perr = 1'b1; tick(2); perr = 1'b0; tick(2); end
        berr = 1'b1; tick(20); berr = 1'b0; tick(3);
        tests++; if (int'(pcnt) !== 3) begin fails++; $display("FAIL err_par3: got %0d required 3", pcnt); end
        tests++; if (int'(bcnt) !== 1) begin fails++; $display("FAIL err_baud_level: got %0d required 1", bcnt); end
        tests++; if (int'(bytecnt) !== 0) begin fails++; $display("FAIL err_byteclr: got %0d required 0", bytecnt); end
        for (int i = 0; i < 10; i++) begin perr = 1'b1; tick(1); perr = 1'b0; tick(1); end
        tick(3);
        tests++; if (int'(pcnt) !== ((13 > MAXC) ? MAXC : 13)) begin fails++; $display("FAIL err_par_sat: got %0d required %0d", pcnt, MAXC); end
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        perr = 1'b1; berr = 1'b1; tick(2); perr = 1'b0; berr = 1'b0; tick(3);
        tests++; if (int'(pcnt) !== 1 || int'(bcnt) !== 1) begin
            fails++; $display("FAIL err_both: got par=%0d baud=%0d required 1 and 1", pcnt, bcnt); end
        clr = 1'b1; tick(1); clr = 1'b0; tick(2);
        // Rising edge reaches the counter two edges after the input changes
        perr = 1'b1; tick(1);
        clr = 1'b1; tick(1); clr = 1'b0; tick(3);
        perr = 1'b0; tick(2);
        tests++; if (int'(pcnt) !== 0) begin fails++; $display("FAIL err_clr_wins: got %0d required 0", pcnt); end
    endtask

    task automatic test_random;
        int p0, a0, n0, bad, ne;
        tick(1);
        p0 = pops; a0 = accepts; n0 = underflow;
        ne = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(3) == 0 && fifo_q.size() < 8) begin push(8'($urandom)); ne++; end
            bus.p_Ready_i = ($urandom_range(2) != 0);
            enable = ($urandom_range(7) != 0);
            tick(1);
        end
        enable = 1'b1;
        bus.p_Ready_i = 1'b1;
        for (int i = 0; i < 200 && (accepts - a0) < ne; i++) @(negedge clk);
        tests++; if (accepts - a0 !== ne) begin fails++; $display("FAIL rand_count: got %0d required %0d", accepts - a0, ne); end
        tests++; if (pops - p0 !== ne) begin fails++; $display("FAIL rand_pops: got %0d required %0d", pops - p0, ne); end
        bad = 0;
        while (exp_q.size() > 0 && got_q.size() > 0) if (exp_q.pop_front() !== got_q.pop_front()) bad++;
        tests++; if (bad !== 0 || exp_q.size() !== 0) begin
            fails++; $display("FAIL rand_order: got %0d wrong, %0d missing required 0 and 0", bad, exp_q.size()); end
        tests++; if (underflow - n0 !== 0 || overrun !== 0) begin
            fails++; $display("FAIL rand_fifo_rules: got underflow=%0d overrun=%0d required 0 and 0", underflow - n0, overrun); end
        tests++; if (unstable !== 0) begin fails++; $display("FAIL rand_stable: got %0d changes required 0", unstable); end
        @(negedge clk);
        tests++; if (int'(bytecnt) !== exp_bytecnt) begin fails++; $display("FAIL rand_bytecnt: got %0d required %0d", bytecnt, exp_bytecnt); end
    endtask

    task automatic test_timeout;
        int a0, t0, h;
        tick(1);
        enable = 1'b1;
        bus.p_Ready_i = 1'b1;
        a0 = accepts;
        push(8'h5A);
        for (int i = 0; i < 20 && accepts == a0; i++) @(negedge clk);
        h  = last_acc_cyc;
        t0 = to_cnt;
        tick(60);
        void'(exp_q.pop_front());
        void'(got_q.pop_front());
`ifdef RX_TIMEOUT_EN
        tests++; if (to_cnt - t0 !== 1) begin fails++; $display("FAIL timeout_pulses: got %0d required 1", to_cnt - t0); end
        tests++; if (last_to_cyc - h !== TOC + 1) begin
            fails++; $display("FAIL timeout_delay: got %0d required %0d", last_to_cyc - h, TOC + 1); end
`else
        tests++; if (to_cnt - t0 !== 0) begin fails++; $display("FAIL timeout_off: got %0d pulses required 0", to_cnt - t0); end
`endif
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_empty();
        test_enable_drop();
        test_errors();
        test_random();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
